// File: rtl/envelope_multi.sv
// envelope_multi: time-multiplexed multi-voice ADSR envelope generator with multiplier handshake
module envelope_multi #(
   parameter int NUM_VOICES = 3,
   parameter int VOL_W      = 24,
   parameter int OUT_W      = 8,
   parameter int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [IDX_W-1:0] voice_idx_i,
   input  logic             gate_i,
   input  logic [3:0]       attack_i,
   input  logic [3:0]       decay_i,
   input  logic [3:0]       sustain_i,
   input  logic [3:0]       release_i,
   input  logic             mult_ready_i,
   output logic             mult_start_o,
   output logic [OUT_W-1:0] env_o,
   output logic [1:0]       env_state_o,
   output logic             ready_o
);
   typedef enum logic [1:0] {ST_A, ST_D, ST_S, ST_R} adsr_t;
   typedef enum logic [1:0] {IDLE, UPD, WAIT, DONE} fsm_t;
   localparam logic [23:0] ATK [16] = '{24'd167116, 24'd41779, 24'd20889, 24'd13926, 24'd8795, 24'd5968,
      24'd4915, 24'd4177, 24'd3342, 24'd1336, 24'd668, 24'd417, 24'd334, 24'd111, 24'd66, 24'd41};
   localparam logic [23:0] DR [16] = '{24'd139262, 24'd34815, 24'd17407, 24'd11605, 24'd7327, 24'd4972,
      24'd4095, 24'd3480, 24'd2785, 24'd1112, 24'd555, 24'd347, 24'd277, 24'd92, 24'd55, 24'd32};
   fsm_t                  r_fsm;
   logic                  r_mult_start, r_ready;
   logic [OUT_W-1:0]      r_env;
   logic [VOL_W-1:0]      r_vol [NUM_VOICES];
   adsr_t                 r_st [NUM_VOICES];
   logic [NUM_VOICES-1:0] r_pg;
   logic                  w_valid, w_pg, w_rise;
   logic [IDX_W-1:0]      w_idx;
   logic [VOL_W-1:0]      w_vol, w_max, w_sus, w_astep, w_dstep, w_nvol;
   logic [VOL_W:0]        w_sum, w_dlim;
   logic [23:0]           w_rate;
   logic [1:0]            w_shift;
   adsr_t                 w_st, w_nst;
   assign w_valid = int'(voice_idx_i) < NUM_VOICES;
   assign w_idx   = w_valid ? voice_idx_i : '0;
   assign w_vol   = w_valid ? r_vol[w_idx] : '0;
   assign w_st    = w_valid ? r_st[w_idx] : ST_R;
   assign w_pg    = w_valid ? r_pg[w_idx] : 1'b0;
   assign w_rise  = gate_i & ~w_pg;
   assign w_max   = '1;
   assign w_sus   = {sustain_i, sustain_i, {(VOL_W-8){1'b0}}};
   always_comb begin
      w_nst   = w_rise ? ST_A :
                (!gate_i && w_st != ST_R) ? ST_R :
                (w_st == ST_A && w_vol == w_max) ? ST_D :
                (w_st == ST_D && w_vol <= w_sus) ? ST_S :
                (w_st == ST_S && w_vol > w_sus) ? ST_D : w_st;
      // exponential curve: step shrinks as the level falls through the top three octaves
      w_shift = w_vol[VOL_W-1] ? 2'd0 : w_vol[VOL_W-2] ? 2'd1 : w_vol[VOL_W-3] ? 2'd2 : 2'd3;
      w_rate  = (w_nst == ST_D) ? DR[decay_i] : DR[release_i];
      w_dstep = ((VOL_W'(w_rate) << (VOL_W-24)) >> w_shift) | VOL_W'(1);
      w_astep = VOL_W'(ATK[attack_i]) << (VOL_W-24);
      w_sum   = {1'b0, w_vol} + {1'b0, w_astep};
      w_dlim  = {1'b0, w_sus} + {1'b0, w_dstep};
      w_nvol  = (w_nst == ST_A) ? (w_sum[VOL_W] ? w_max : w_sum[VOL_W-1:0]) :
                (w_nst == ST_D) ? (({1'b0, w_vol} <= w_dlim) ? w_sus : w_vol - w_dstep) :
                (w_nst == ST_R) ? ((w_vol <= w_dstep) ? {VOL_W{1'b0}} : w_vol - w_dstep) : w_vol;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_fsm        <= IDLE;
         r_mult_start <= 1'b0;
         r_ready      <= 1'b0;
         r_env        <= '0;
         r_pg         <= '0;
         for (int v = 0; v < NUM_VOICES; v++) begin
            r_vol[v] <= '0;
            r_st[v]  <= ST_R;
         end
      end else begin
         case (r_fsm)
            IDLE: if (start_i) begin
               r_fsm        <= UPD;
               r_mult_start <= 1'b1;
            end
            UPD: begin
               r_fsm        <= WAIT;
               r_mult_start <= 1'b0;
               if (w_valid) begin
                  r_vol[w_idx] <= w_nvol;
                  r_st[w_idx]  <= w_nst;
                  r_pg[w_idx]  <= gate_i;
                  r_env        <= w_nvol[VOL_W-1 -: OUT_W];
               end
            end
            WAIT: if (mult_ready_i) begin
               r_fsm   <= DONE;
               r_ready <= 1'b1;
            end
            DONE: begin
               r_fsm   <= IDLE;
               r_ready <= 1'b0;
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end
   assign mult_start_o = r_mult_start;
   assign ready_o      = r_ready;
   assign env_o        = r_env;
   assign env_state_o  = w_st;
endmodule
